// File: rtl/alu_seq.sv
// alu_seq: single-issue ALU with iterative shift-add multiplier.
// Valid/ready request in, valid/ready registered result and flags out.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_e;

  localparam int W2 = 2 * WIDTH;
  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH);

  localparam logic [WIDTH-1:0] WMOD = WIDTH'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  state_e           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic [W2-1:0]    acc_q;
  logic [W2-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;

  logic             accept;
  logic             op_add;
  logic             op_sub;
  logic             op_and;
  logic             op_or;
  logic             op_xor;
  logic             op_shl;
  logic             op_shr;
  logic             op_mul;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH:0]   shl_w;
  logic [WIDTH:0]   shr_w;
  logic [WIDTH-1:0] s_full;
  logic [SW-1:0]    sh;

  logic [WIDTH-1:0] alu_res_d;
  logic             alu_c_d;
  logic             alu_v_d;
  logic [W2-1:0]    acc_d;
  logic [WIDTH-1:0] mul_res_d;
  logic             mul_c_d;

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

  assign op_add = (alu_op == OP_ADD);
  assign op_sub = (alu_op == OP_SUB);
  assign op_and = (alu_op == OP_AND);
  assign op_or  = (alu_op == OP_OR);
  assign op_xor = (alu_op == OP_XOR);
  assign op_shl = (alu_op == OP_SHL);
  assign op_shr = (alu_op == OP_SHR);
  assign op_mul = (alu_op == OP_MUL);

  // Flag pack: {negative, overflow, carry, zero}.
  function automatic logic [3:0] mk_flags(
    input logic [WIDTH-1:0] r,
    input logic             v,
    input logic             c
  );
    return {r[WIDTH-1], v, c, (r == '0)};
  endfunction

  // Single-cycle datapath for every op except MUL.
  always_comb begin
    alu_res_d = '0;
    alu_c_d   = 1'b0;
    alu_v_d   = 1'b0;
    sum_w     = {1'b0, a} + {1'b0, b};
    diff_w    = {1'b0, a} - {1'b0, b};
    s_full    = b % WMOD;
    sh        = s_full[SW-1:0];
    shl_w     = {1'b0, a} << sh;
    shr_w     = {a, 1'b0} >> sh;
    unique case (1'b1)
      op_add: begin
        alu_res_d = sum_w[WIDTH-1:0];
        alu_c_d   = sum_w[WIDTH];
        alu_v_d   = (a[WIDTH-1] == b[WIDTH-1]) &&
                    (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      op_sub: begin
        alu_res_d = diff_w[WIDTH-1:0];
        alu_c_d   = diff_w[WIDTH];
        alu_v_d   = (a[WIDTH-1] != b[WIDTH-1]) &&
                    (diff_w[WIDTH-1] != a[WIDTH-1]);
      end
      op_and: alu_res_d = a & b;
      op_or:  alu_res_d = a | b;
      op_xor: alu_res_d = a ^ b;
      op_shl: begin
        alu_res_d = shl_w[WIDTH-1:0];
        alu_c_d   = shl_w[WIDTH];
      end
      op_shr: begin
        alu_res_d = shr_w[WIDTH:1];
        alu_c_d   = shr_w[0];
      end
      op_mul: alu_res_d = '0;
      default: alu_res_d = '0;
    endcase
  end

  // One shift-add step: consume the multiplier LSB.
  always_comb begin
    acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
    mul_res_d = acc_d[WIDTH-1:0];
    mul_c_d   = |acc_d[W2-1:WIDTH];
  end

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (op_mul) begin
              state_q  <= S_MUL;
              acc_q    <= '0;
              mcand_q  <= {{WIDTH{1'b0}}, a};
              mplier_q <= b;
              cnt_q    <= '0;
            end else begin
              state_q     <= S_DONE;
              result_q    <= alu_res_d;
              flags_q     <= mk_flags(alu_res_d, alu_v_d, alu_c_d);
              out_valid_q <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q     <= S_DONE;
            result_q    <= mul_res_d;
            flags_q     <= mk_flags(mul_res_d, 1'b0, mul_c_d);
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq at WIDTH=8.
// Hand-computed results, flags and latencies.
module tb_alu_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] alu_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [3:0] flags;

  int total;
  int bad;

  alu_seq #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .alu_op   (alu_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flags    (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one op, wait for out_valid, optionally stall, then drain.
  task automatic do_op(
    input string      tag,
    input logic [2:0] op,
    input logic [7:0] av,
    input logic [7:0] bv,
    input logic [7:0] er,
    input logic [3:0] ef,
    input int         elat,
    input int         hold
  );
    int k;
    @(negedge clk);
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    alu_op   = op;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = ~av;
    b        = ~bv;
    k = 1;
    while (!out_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, "_lat"}, 32'(k), 32'(elat));
    check({tag, "_res"}, 32'(result), 32'(er));
    check({tag, "_flg"}, 32'(flags), 32'(ef));
    if (hold > 0) begin
      in_valid = 1'b1;
      alu_op   = 3'b000;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hv"}, 32'(out_valid), 32'd1);
      check({tag, "_hr"}, 32'(result), 32'(er));
      check({tag, "_hf"}, 32'(flags), 32'(ef));
      check({tag, "_hrdy"}, 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    alu_op    = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", 32'(in_ready), 32'd0);
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_res", 32'(result), 32'd0);
    check("rst_flg", 32'(flags), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_rdy", 32'(in_ready), 32'd1);

    do_op("add_ff01", 3'b000, 8'hFF, 8'h01, 8'h00, 4'b0011, 1, 0);
    do_op("add_7f01", 3'b000, 8'h7F, 8'h01, 8'h80, 4'b1100, 1, 0);
    do_op("sub_8001", 3'b001, 8'h80, 8'h01, 8'h7F, 4'b0100, 1, 0);
    do_op("sub_0102", 3'b001, 8'h01, 8'h02, 8'hFF, 4'b1010, 1, 0);
    do_op("and", 3'b010, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1, 0);
    do_op("or", 3'b011, 8'h80, 8'h01, 8'h81, 4'b1000, 1, 0);
    do_op("xor", 3'b100, 8'hAA, 8'hAA, 8'h00, 4'b0001, 1, 0);
    do_op("shl_s1", 3'b101, 8'h81, 8'h09, 8'h02, 4'b0010, 1, 0);
    do_op("shr_s0", 3'b110, 8'h81, 8'h00, 8'h81, 4'b1000, 1, 0);
    do_op("shr_s3", 3'b110, 8'h81, 8'h03, 8'h10, 4'b0000, 1, 0);
    do_op("shr_s2", 3'b110, 8'h86, 8'h02, 8'h21, 4'b0010, 1, 0);
    do_op("mul_0f11", 3'b111, 8'h0F, 8'h11, 8'hFF, 4'b1000, 9, 0);
    do_op("mul_1010", 3'b111, 8'h10, 8'h10, 8'h00, 4'b0011, 9, 0);
    do_op("mul_0d0b", 3'b111, 8'h0D, 8'h0B, 8'h8F, 4'b1000, 9, 0);
    do_op("bp_sub", 3'b001, 8'h05, 8'h03, 8'h02, 4'b0000, 1, 5);

    @(negedge clk);
    in_valid = 1'b1;
    alu_op   = 3'b111;
    a        = 8'h0F;
    b        = 8'h11;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_ov", 32'(out_valid), 32'd0);
    check("mrst_res", 32'(result), 32'd0);
    check("mrst_flg", 32'(flags), 32'd0);
    check("mrst_rdy", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mrst_rel", 32'(in_ready), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    check("mrst_gone", 32'(out_valid), 32'd0);
    do_op("add_0203", 3'b000, 8'h02, 8'h03, 8'h05, 4'b0000, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal values 4..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  operation request present.
REQ-005 Port: in_ready  output  1  block can accept a request.
REQ-006 Port: a  input  WIDTH  operand A.
REQ-007 Port: b  input  WIDTH  operand B; also the shift amount for SHL/SHR.
REQ-008 Port: alu_op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-009 Port: out_valid  output  1  result and flags are valid.
REQ-010 Port: out_ready  input  1  consumer takes the result.
REQ-011 Port: result  output  WIDTH  registered result.
REQ-012 Port: flags  output  4  registered {negative, overflow, carry, zero}, in that order from MSB to LSB.

Function
REQ-013 States SHALL be IDLE, MUL, DONE; in_ready SHALL equal (state==IDLE) and not rst.
REQ-014 Accept SHALL occur on a cycle with in_valid and in_ready both high; a, b and alu_op SHALL be captured at accept.
REQ-015 Non-MUL op accepted at edge T: result/flags SHALL be loaded and out_valid SHALL be high from T+1 (state DONE).
REQ-016 MUL accepted at edge T: state MUL, iterative shift-add, one multiplier bit per cycle, for WIDTH cycles; out_valid SHALL be high from T+WIDTH+1.
REQ-017 In DONE, result, flags and out_valid SHALL hold stable until out_ready is high; on that edge state SHALL go to IDLE and out_valid SHALL drop.
REQ-018 No back-to-back accept from DONE: in_ready SHALL be high one cycle after the out_ready handshake; in_valid is ignored outside IDLE.
REQ-019 ADD/SUB SHALL be modulo 2^WIDTH; carry = carry-out for ADD and borrow (a<b unsigned) for SUB; overflow = two's-complement signed overflow.
REQ-020 AND/OR/XOR: bitwise; carry=0, overflow=0.
REQ-021 SHL/SHR: logical shift by s = b mod WIDTH; carry = last bit shifted out, or 0 when s=0; overflow=0.
REQ-022 MUL: unsigned; result = low WIDTH bits of product; carry=1 iff the high WIDTH bits are nonzero; overflow=0.
REQ-023 zero = (result==0); negative = result[WIDTH-1], for all ops.

Reset
REQ-024 While rst is high at an edge, state SHALL go to IDLE, out_valid=0, result=0, flags=0, and any in-flight MUL SHALL be discarded.
REQ-025 in_ready SHALL be 0 while rst is high and 1 on the first cycle after rst deasserts.
REQ-026 rst SHALL take priority over accept and out_ready handshakes in the same cycle.

Verification (WIDTH=8)
REQ-027 ADD a=FF b=01 -> result=00, flags=0011 (carry, zero), out_valid at T+1.
REQ-028 SUB a=80 b=01 -> result=7F, flags=0100 (overflow only); SUB a=01 b=02 -> result=FF, flags=1010.
REQ-029 MUL a=0F b=11 -> result=FF, flags=1000, out_valid first high at T+9; MUL a=10 b=10 -> result=00, flags=0011.
REQ-030 SHL a=81 b=09 (s=1) -> result=02, carry=1; SHR a=81 b=00 -> result=81, flags=1000.
REQ-031 Backpressure: out_ready held low 5 cycles after out_valid -> result/flags/out_valid stable, in_ready=0; out_ready high -> in_ready=1 on next cycle.
REQ-032 Reset mid-MUL: rst pulsed 3 cycles after accept -> out_valid=0, result=00, flags=0000; after release, a new ADD 02+03 returns 05 at T+1.
